cla_serial_add_ctrl: RTL

Sequencer that performs WIDTH-bit add/subtract using a single 4-bit carry-lookahead slice, iterated once per nibble, least-significant nibble first. Operands arrive on a valid/ready request port. The result leaves on a valid/ready response port. It replaces a full-width adder in area-constrained datapaths, trading latency for one shared CLA slice plus a carry register.

---
 rtl/cla_serial_add_ctrl_pkg.sv | 17 +
 rtl/cla_serial_add_ctrl_cla4_slice.sv | 28 ++
 rtl/cla_serial_add_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cla_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial CLA add/subtract sequencer.
package cla_serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIB_W = 4;

   // Operand width must split into whole nibbles, at least one.
   function automatic bit width_ok(input int w);
      return (w >= NIB_W) && ((w % NIB_W) == 0);
   endfunction

endpackage

// File: rtl/cla_serial_add_ctrl_cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice (flat generate/propagate terms).
module cla4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is a two-level sum of products of g/p/cin, so no carry waits on another.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum  = p ^ c[3:0];
   assign cout = c[4];

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// WIDTH-bit add/subtract performed one nibble per cycle through a single shared CLA slice.
module cla_serial_add_ctrl
   import cla_serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy
);

   localparam int NS    = WIDTH / NIB_W;
   localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NS - 1);

   generate
      if (!width_ok(WIDTH)) begin : g_width_chk
         $error("cla_serial_add_ctrl: WIDTH must be a positive multiple of 4");
      end
   endgenerate

   state_t                      state;
   state_t                      next_state;
   logic [IDX_W-1:0]            idx;
   logic                        carry;
   logic                        out_valid_r;
   logic [NS-1:0][NIB_W-1:0]    a_reg;
   logic [NS-1:0][NIB_W-1:0]    b_reg;
   logic [NS-1:0][NIB_W-1:0]    sum_reg;
   logic [NIB_W-1:0]            sl_a;
   logic [NIB_W-1:0]            sl_b;
   logic [NIB_W-1:0]            sl_sum;
   logic                        sl_cout;
   logic                        accept;

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_r;
   assign out_sum   = sum_reg;
   assign out_cout  = carry;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid)           next_state = RUN;
         RUN:     if (idx == IDX_LAST)    next_state = DONE;
         DONE:    if (out_ready)          next_state = IDLE;
         default:                         next_state = IDLE;
      endcase
   end

   // Nibble select by compare-per-index keeps the mux clean for any NS, including 1.
   always_comb begin
      sl_a = '0;
      sl_b = '0;
      for (int i = 0; i < NS; i++) begin
         if (idx == IDX_W'(i)) begin
            sl_a = a_reg[i];
            sl_b = b_reg[i];
         end
      end
   end

   cla4_slice u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry),
      .sum  (sl_sum),
      .cout (sl_cout)
   );

   // Operands are pure data: captured on accept, never cleared.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_reg <= in_a;
         b_reg <= in_sub ? ~in_b : in_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx         <= '0;
         carry       <= 1'b0;
         sum_reg     <= '0;
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= (next_state == DONE);
         case (state)
            IDLE: begin
               if (accept) begin
                  carry   <= in_sub ? 1'b1 : in_cin;
                  idx     <= '0;
                  sum_reg <= '0;
               end
            end
            RUN: begin
               for (int i = 0; i < NS; i++) begin
                  if (idx == IDX_W'(i)) sum_reg[i] <= sl_sum;
               end
               carry <= sl_cout;
               if (idx != IDX_LAST) idx <= idx + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
